// File: rtl/rx_sp_pkg.sv
// Shared constants and types for the receive-side stream splitter.
package rx_sp_pkg;

    localparam logic [15:0] ETH_TYPE_IP  = 16'h0800;
    localparam logic [15:0] ETH_TYPE_ARP = 16'h0806;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned WORD_W = 35;
    localparam int unsigned TAG_W  = 2;

    typedef enum logic [1:0] {
        TAG_IP   = 2'd0,
        TAG_ARP  = 2'd1,
        TAG_DROP = 2'd2
    } tag_e;

    // Data FIFO entry: one 32-bit frame word plus its end-of-frame info.
    typedef struct packed {
        logic              eop;
        logic [1:0]        mod;
        logic [DATA_W-1:0] data;
    } rx_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HI   = 2'd1,
        ST_LO   = 2'd2,
        ST_DROP = 2'd3
    } rd_state_e;

    function automatic tag_e classify(input logic [15:0] etype);
        case (etype)
            ETH_TYPE_IP:  classify = TAG_IP;
            ETH_TYPE_ARP: classify = TAG_ARP;
            default:      classify = TAG_DROP;
        endcase
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered used-word count.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wr_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rd_data_c,
    output logic                       empty_c,
    output logic [$clog2(DEPTH):0]     used
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned UW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push_c;
    logic             do_pop_c;

    always_comb begin
        empty_c   = (used == '0);
        do_push_c = push && (used != UW'(DEPTH));
        do_pop_c  = pop && !empty_c;
        rd_data_c = mem[rd_ptr];
    end

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push_c) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            used   <= '0;
        end else begin
            if (do_push_c) begin
                wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            end
            if (do_pop_c) begin
                rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            end
            used <= used + UW'(do_push_c) - UW'(do_pop_c);
        end
    end

endmodule

// File: rtl/rx_sp.sv
// Receive splitter: narrows 32-bit MAC frames to 16-bit beats and routes
// each whole frame to the IP or ARP stream by EtherType, dropping the rest.
module rx_sp
    import rx_sp_pkg::*;
#(
    parameter int unsigned DATA_DEPTH = 32,
    parameter int unsigned TAG_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] rx_data,
    input  logic        rx_vld,
    input  logic        rx_sop,
    input  logic        rx_eop,
    input  logic [1:0]  rx_mod,
    output logic        rx_rdy,
    output logic [15:0] ip_data,
    output logic        ip_vld,
    output logic        ip_sop,
    output logic        ip_eop,
    output logic        ip_mod,
    input  logic        ip_rdy,
    output logic [15:0] arp_data,
    output logic        arp_vld,
    output logic        arp_sop,
    output logic        arp_eop,
    output logic        arp_mod,
    input  logic        arp_rdy
);
    localparam int unsigned DUW = $clog2(DATA_DEPTH) + 1;
    localparam int unsigned TUW = $clog2(TAG_DEPTH) + 1;

    logic              frame_open;
    logic [2:0]        wcnt;
    logic              start_c;
    logic              in_frame_c;
    logic [2:0]        idx_c;
    logic              tag_push_c;
    tag_e              tag_in_c;
    rx_word_t          wr_word_c;

    logic [WORD_W-1:0] data_rd_c;
    logic              data_empty_c;
    logic [DUW-1:0]    data_used;
    logic [TAG_W-1:0]  tag_rd_c;
    logic              tag_empty_c;
    logic [TUW-1:0]    tag_used;

    rd_state_e         state;
    logic              dest_arp;
    logic              first;
    logic              ip_rdy_ff;
    logic              arp_rdy_ff;
    rx_word_t          head_c;
    logic              sel_rdy_c;
    logic              beat_ok_c;
    logic              hi_last_c;
    logic              data_pop_c;
    logic              tag_pop_c;

    // Write side: frame tracking, word index and tag decision.
    always_comb begin
        start_c    = rx_vld && rx_sop && !frame_open;
        in_frame_c = rx_vld && (frame_open || rx_sop);
        idx_c      = start_c ? 3'd0 : wcnt;
        tag_push_c = in_frame_c && ((idx_c == 3'd3) || (rx_eop && (idx_c < 3'd3)));
        tag_in_c   = (idx_c == 3'd3) ? classify(rx_data[31:16]) : TAG_DROP;
        wr_word_c  = '{eop: rx_eop, mod: rx_mod, data: rx_data};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_open <= 1'b0;
            wcnt       <= 3'd0;
            rx_rdy     <= 1'b0;
        end else begin
            if (in_frame_c) begin
                frame_open <= !rx_eop;
                wcnt       <= (idx_c == 3'd4) ? 3'd4 : idx_c + 3'd1;
            end
            // Margin covers words already in flight behind a registered rdy.
            rx_rdy <= (data_used < DUW'(DATA_DEPTH - 4)) && (tag_used < TUW'(TAG_DEPTH - 1));
        end
    end

    sync_fifo #(.WIDTH(WORD_W), .DEPTH(DATA_DEPTH)) u_data_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (in_frame_c),
        .wr_data   (wr_word_c),
        .pop       (data_pop_c),
        .rd_data_c (data_rd_c),
        .empty_c   (data_empty_c),
        .used      (data_used)
    );

    sync_fifo #(.WIDTH(TAG_W), .DEPTH(TAG_DEPTH)) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (tag_push_c),
        .wr_data   (tag_in_c),
        .pop       (tag_pop_c),
        .rd_data_c (tag_rd_c),
        .empty_c   (tag_empty_c),
        .used      (tag_used)
    );

    // Read side gating: a beat needs data and rdy high on both recent edges.
    always_comb begin
        head_c     = rx_word_t'(data_rd_c);
        sel_rdy_c  = dest_arp ? (arp_rdy_ff && arp_rdy) : (ip_rdy_ff && ip_rdy);
        beat_ok_c  = !data_empty_c && sel_rdy_c;
        hi_last_c  = head_c.eop && (head_c.mod >= 2'd2);
        tag_pop_c  = 1'b0;
        data_pop_c = 1'b0;
        case (state)
            ST_IDLE: tag_pop_c  = !tag_empty_c;
            ST_HI:   data_pop_c = beat_ok_c && hi_last_c;
            ST_LO:   data_pop_c = beat_ok_c;
            ST_DROP: data_pop_c = !data_empty_c;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            dest_arp   <= 1'b0;
            first      <= 1'b0;
            ip_rdy_ff  <= 1'b0;
            arp_rdy_ff <= 1'b0;
            ip_data    <= 16'h0;
            ip_vld     <= 1'b0;
            ip_sop     <= 1'b0;
            ip_eop     <= 1'b0;
            ip_mod     <= 1'b0;
            arp_data   <= 16'h0;
            arp_vld    <= 1'b0;
            arp_sop    <= 1'b0;
            arp_eop    <= 1'b0;
            arp_mod    <= 1'b0;
        end else begin
            ip_rdy_ff  <= ip_rdy;
            arp_rdy_ff <= arp_rdy;
            ip_vld     <= 1'b0;
            ip_sop     <= 1'b0;
            ip_eop     <= 1'b0;
            ip_mod     <= 1'b0;
            arp_vld    <= 1'b0;
            arp_sop    <= 1'b0;
            arp_eop    <= 1'b0;
            arp_mod    <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (!tag_empty_c) begin
                        dest_arp <= (tag_e'(tag_rd_c) == TAG_ARP);
                        first    <= 1'b1;
                        state    <= (tag_e'(tag_rd_c) == TAG_DROP) ? ST_DROP : ST_HI;
                    end
                end
                ST_HI: begin
                    if (beat_ok_c) begin
                        if (dest_arp) begin
                            arp_vld  <= 1'b1;
                            arp_sop  <= first;
                            arp_eop  <= hi_last_c;
                            arp_mod  <= hi_last_c && (head_c.mod == 2'd3);
                            arp_data <= head_c.data[31:16];
                        end else begin
                            ip_vld   <= 1'b1;
                            ip_sop   <= first;
                            ip_eop   <= hi_last_c;
                            ip_mod   <= hi_last_c && (head_c.mod == 2'd3);
                            ip_data  <= head_c.data[31:16];
                        end
                        first <= 1'b0;
                        state <= hi_last_c ? ST_IDLE : ST_LO;
                    end
                end
                ST_LO: begin
                    if (beat_ok_c) begin
                        if (dest_arp) begin
                            arp_vld  <= 1'b1;
                            arp_eop  <= head_c.eop;
                            arp_mod  <= head_c.eop && (head_c.mod == 2'd1);
                            arp_data <= head_c.data[15:0];
                        end else begin
                            ip_vld   <= 1'b1;
                            ip_eop   <= head_c.eop;
                            ip_mod   <= head_c.eop && (head_c.mod == 2'd1);
                            ip_data  <= head_c.data[15:0];
                        end
                        state <= head_c.eop ? ST_IDLE : ST_HI;
                    end
                end
                ST_DROP: begin
                    if (!data_empty_c && head_c.eop) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rx_sp.sv
// Self-checking bench for rx_sp: frame table plus hand-written corner sequences.
module tb_rx_sp;
    localparam int unsigned DATA_DEPTH = 32;
    localparam int unsigned TAG_DEPTH  = 4;

    logic        clk;
    logic        rst_n;
    logic [31:0] rx_data;
    logic        rx_vld, rx_sop, rx_eop;
    logic [1:0]  rx_mod;
    logic        rx_rdy;
    logic [15:0] ip_data, arp_data;
    logic        ip_vld, ip_sop, ip_eop, ip_mod, ip_rdy;
    logic        arp_vld, arp_sop, arp_eop, arp_mod, arp_rdy;

    rx_sp #(.DATA_DEPTH(DATA_DEPTH), .TAG_DEPTH(TAG_DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .rx_data(rx_data), .rx_vld(rx_vld), .rx_sop(rx_sop), .rx_eop(rx_eop),
        .rx_mod(rx_mod), .rx_rdy(rx_rdy),
        .ip_data(ip_data), .ip_vld(ip_vld), .ip_sop(ip_sop), .ip_eop(ip_eop),
        .ip_mod(ip_mod), .ip_rdy(ip_rdy),
        .arp_data(arp_data), .arp_vld(arp_vld), .arp_sop(arp_sop), .arp_eop(arp_eop),
        .arp_mod(arp_mod), .arp_rdy(arp_rdy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic        mod;
        logic [15:0] data;
    } beat_t;

    typedef struct {
        int          nbytes;
        logic [7:0]  base;
        logic [15:0] etype;
        int          dest;     // 0 ip, 1 arp, 2 dropped
        int          nbeats;
        logic        lastmod;
    } vec_t;

    beat_t      cap_ip[$], cap_arp[$], exp_ip[$], exp_arp[$];
    logic [7:0] fb[$];
    int         checks = 0;
    int         errors = 0;
    int         viol = 0;
    logic       rx_rdy_prev = 1'b0, ip_rdy_prev = 1'b0, arp_rdy_prev = 1'b0;
    logic       rnd_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Output monitor: capture beats and count handshake violations.
    always @(negedge clk) begin
        if (rst_n) begin
            if (ip_vld) begin
                cap_ip.push_back('{sop: ip_sop, eop: ip_eop, mod: ip_mod, data: ip_data});
                if (!ip_rdy_prev) viol++;
            end
            if (arp_vld) begin
                cap_arp.push_back('{sop: arp_sop, eop: arp_eop, mod: arp_mod, data: arp_data});
                if (!arp_rdy_prev) viol++;
            end
            if (ip_vld && arp_vld) viol++;
            if (rx_vld && !rx_rdy_prev) viol++;
        end
        rx_rdy_prev  <= rx_rdy;
        ip_rdy_prev  <= ip_rdy;
        arp_rdy_prev <= arp_rdy;
    end

    // Downstream ready: always high, or random when backpressure is enabled.
    initial begin
        ip_rdy  = 1'b1;
        arp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (rnd_en) begin
                ip_rdy  = 1'($urandom_range(0, 1));
                arp_rdy = 1'($urandom_range(0, 1));
            end else begin
                ip_rdy  = 1'b1;
                arp_rdy = 1'b1;
            end
        end
    end

    task automatic make_frame(input int nbytes, input logic [7:0] base, input logic [15:0] etype);
        fb.delete();
        for (int i = 0; i < nbytes; i++) fb.push_back(8'(base + 8'(i)));
        if (nbytes >= 14) begin
            fb[12] = etype[15:8];
            fb[13] = etype[7:0];
        end
    endtask

    // Sends fb as 32-bit words; stop_after >= 0 abandons the frame after that many words.
    task automatic send_frame(input int stop_after);
        int n, nw;
        logic [1:0] m;
        logic [31:0] w32;
        n  = fb.size();
        nw = (n + 3) / 4;
        m  = 2'(nw * 4 - n);
        for (int w = 0; w < nw; w++) begin
            int g;
            g = 0;
            @(posedge clk);
            #1;
            if (stop_after >= 0 && w >= stop_after) begin
                rx_vld = 1'b0;
                return;
            end
            while (!rx_rdy_prev && g < 5000) begin
                rx_vld = 1'b0;
                @(posedge clk);
                #1;
                g++;
            end
            if (g >= 5000) begin
                chk("rx_rdy_wait", 32'd0, 32'd1);
                rx_vld = 1'b0;
                return;
            end
            for (int j = 0; j < 4; j++) begin
                w32[31-8*j -: 8] = (4*w + j < n) ? fb[4*w + j] : 8'hA5;
            end
            rx_data = w32;
            rx_vld  = 1'b1;
            rx_sop  = (w == 0);
            rx_eop  = (w == nw - 1);
            rx_mod  = (w == nw - 1) ? m : 2'd0;
        end
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        rx_sop = 1'b0;
        rx_eop = 1'b0;
        rx_mod = 2'd0;
    endtask

    task automatic add_exp(input int dest, input int nbeats, input logic lastmod);
        beat_t b;
        for (int k = 0; k < nbeats; k++) begin
            b.data = {fb[2*k], (2*k + 1 < fb.size()) ? fb[2*k + 1] : 8'h00};
            b.sop  = (k == 0);
            b.eop  = (k == nbeats - 1);
            b.mod  = (k == nbeats - 1) ? lastmod : 1'b0;
            if (dest == 0) exp_ip.push_back(b);
            else if (dest == 1) exp_arp.push_back(b);
        end
    endtask

    task automatic drain_and_compare(input string tag);
        int g;
        beat_t a, e;
        g = 0;
        while ((cap_ip.size() < exp_ip.size() || cap_arp.size() < exp_arp.size()) && g < 4000) begin
            @(posedge clk);
            g++;
        end
        repeat (30) @(posedge clk);
        chk({tag, "_ip_count"}, 32'(cap_ip.size()), 32'(exp_ip.size()));
        chk({tag, "_arp_count"}, 32'(cap_arp.size()), 32'(exp_arp.size()));
        for (int i = 0; i < exp_ip.size() && i < cap_ip.size(); i++) begin
            a = cap_ip[i];
            e = exp_ip[i];
            if (e.mod) begin a.data[7:0] = 8'h00; e.data[7:0] = 8'h00; end
            chk($sformatf("%s_ip_beat%0d", tag, i), 32'(a), 32'(e));
        end
        for (int i = 0; i < exp_arp.size() && i < cap_arp.size(); i++) begin
            a = cap_arp[i];
            e = exp_arp[i];
            if (e.mod) begin a.data[7:0] = 8'h00; e.data[7:0] = 8'h00; end
            chk($sformatf("%s_arp_beat%0d", tag, i), 32'(a), 32'(e));
        end
        chk({tag, "_protocol"}, 32'(viol), 32'd0);
        cap_ip.delete();
        cap_arp.delete();
        exp_ip.delete();
        exp_arp.delete();
    endtask

    initial begin
        vec_t        tbl[7];
        logic [31:0] arp_words[11];
        logic [15:0] arp_beats[21];
        beat_t       b;

        tbl[0] = '{48, 8'h00, 16'h0800, 0, 24, 1'b0};
        tbl[1] = '{47, 8'h30, 16'h0800, 0, 24, 1'b1};
        tbl[2] = '{45, 8'h60, 16'h0800, 0, 23, 1'b1};
        tbl[3] = '{60, 8'h90, 16'h86dd, 2, 0,  1'b0};
        tbl[4] = '{8,  8'hc0, 16'h0800, 2, 0,  1'b0};
        tbl[5] = '{46, 8'hd0, 16'h0806, 1, 23, 1'b0};
        tbl[6] = '{64, 8'h10, 16'h0806, 1, 32, 1'b0};

        arp_words = '{32'hffffffff, 32'hffff2c02, 32'h03040507, 32'h08060001,
                      32'h08000604, 32'h00012c02, 32'h03040507, 32'hc0a80101,
                      32'h00000000, 32'h0000c0a8, 32'h010ac0a8};
        arp_beats = '{16'hffff, 16'hffff, 16'hffff, 16'h2c02, 16'h0304, 16'h0507,
                      16'h0806, 16'h0001, 16'h0800, 16'h0604, 16'h0001, 16'h2c02,
                      16'h0304, 16'h0507, 16'hc0a8, 16'h0101, 16'h0000, 16'h0000,
                      16'h0000, 16'hc0a8, 16'h010a};

        rst_n = 1'b0; rx_data = '0; rx_vld = 0; rx_sop = 0; rx_eop = 0; rx_mod = '0;
        repeat (3) @(negedge clk);
        chk("reset_ip_side", {11'd0, rx_rdy, ip_vld, ip_sop, ip_eop, ip_mod, ip_data}, 32'd0);
        chk("reset_arp_side", {12'd0, arp_vld, arp_sop, arp_eop, arp_mod, arp_data}, 32'd0);
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        chk("rx_rdy_after_reset", 32'(rx_rdy), 32'd0);
        @(negedge clk);
        chk("rx_rdy_rises", 32'(rx_rdy), 32'd1);

        // ARP request, 42 bytes, last word carries two valid bytes.
        fb.delete();
        for (int w = 0; w < 11; w++) begin
            for (int j = 0; j < 4; j++) begin
                if (4*w + j < 42) fb.push_back(arp_words[w][31-8*j -: 8]);
            end
        end
        send_frame(-1);
        for (int k = 0; k < 21; k++) begin
            b = '{sop: (k == 0), eop: (k == 20), mod: 1'b0, data: arp_beats[k]};
            exp_arp.push_back(b);
        end
        drain_and_compare("arp42");

        // Table of IP, odd-length, dropped and ARP frames.
        for (int i = 0; i < 7; i++) begin
            make_frame(tbl[i].nbytes, tbl[i].base, tbl[i].etype);
            send_frame(-1);
            add_exp(tbl[i].dest, tbl[i].nbeats, tbl[i].lastmod);
        end
        drain_and_compare("table");

        // Alternating IP/ARP frames under random downstream backpressure.
        rnd_en = 1'b1;
        for (int i = 0; i < 20; i++) begin
            int n;
            n = 50 + 3 * i;
            make_frame(n, 8'(i * 7), (i % 2 == 0) ? 16'h0800 : 16'h0806);
            send_frame(-1);
            add_exp(i % 2, (n + 1) / 2, 1'(n % 2));
        end
        drain_and_compare("backpressure");
        rnd_en = 1'b0;
        repeat (3) @(posedge clk);

        // Reset in the middle of an IP frame, then a clean ARP frame.
        make_frame(64, 8'h20, 16'h0800);
        send_frame(5);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midreset_ip_side", {11'd0, rx_rdy, ip_vld, ip_sop, ip_eop, ip_mod, ip_data}, 32'd0);
        chk("midreset_arp_side", {12'd0, arp_vld, arp_sop, arp_eop, arp_mod, arp_data}, 32'd0);
        cap_ip.delete();
        cap_arp.delete();
        exp_ip.delete();
        exp_arp.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        make_frame(50, 8'h40, 16'h0806);
        send_frame(-1);
        add_exp(1, 25, 1'b0);
        drain_and_compare("after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rx_sp.md
# rx_sp

Receive-side stream splitter, the mirror of the transmit packer. Takes the 32-bit Ethernet frame stream from the MAC receive path and narrows it to 16-bit beats. Inspects the EtherType and routes each whole frame, header included and unmodified, to either the IP stream or the ARP stream. Frames of any other type, and runt frames, are silently dropped.

## Interface
- DATA_DEPTH, 32: data FIFO depth in 32-bit words; power of 2, ≥16
- TAG_DEPTH, 4: tag FIFO depth in frames
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- rx_data  in  32  frame word; byte 0 is in [31:24]
- rx_vld  in  1  word valid
- rx_sop  in  1  first word of frame
- rx_eop  in  1  last word of frame
- rx_mod  in  2  invalid bytes in the eop word (0–3), low-order bytes
- rx_rdy  out  1  may accept; a vld at cycle n is legal only if rx_rdy was 1 at n-1
- ip_data  out  16  IP frame beat; byte 0 is in [15:8]
- ip_vld, ip_sop, ip_eop  out  1 each
- ip_mod  out  1  1 = low byte of the eop beat is invalid
- ip_rdy  in  1  same rule: ip_vld at n only if ip_rdy was 1 at n-1
- arp_data, arp_vld, arp_sop, arp_eop, arp_mod, arp_rdy: same as the ip_* ports, for ARP

## Operation
- **Write side**
  - Every accepted word inside a frame is pushed to the data FIFO as {eop, mod, data}.
  - A frame opens on rx_vld&rx_sop.
  - Words arriving while no frame is open are discarded.
  - rx_sop inside an open frame is ignored; the word is treated as data.
- **Word counter** (wcnt)
  - Cleared at sop; counts words.
  - At wcnt==3, rx_data[31:16] is the EtherType.
    - 0x0800 → push tag IP.
    - 0x0806 → push tag ARP.
    - Any other value → push tag DROP.
  - If eop arrives with wcnt<3, push tag DROP at eop (runt frame).
- **Read FSM** states: IDLE, HI, LO, DROP.
  - IDLE: when the tag FIFO is non-empty, pop the tag and select the destination. DROP → DROP state, otherwise → HI.
  - HI: emit data[31:16] when the data FIFO is non-empty and the selected rdy_ff==1.
    - sop is set on the first beat of the frame.
    - If the word is eop and valid bytes v=4-mod ≤2: set eop, mod=(v==1), pop the word, go to IDLE.
    - Otherwise go to LO.
  - LO: emit data[15:0] under the same gating, pop the word.
    - If eop: set eop, mod=(v==3), go to IDLE.
    - Otherwise go to HI.
  - DROP: pop one word per cycle. After popping the eop word, go to IDLE.
- Beats are only emitted to the selected port. The other port's vld stays 0.
- Output ordering equals input ordering; the two destinations never interleave within a frame.

## Timing
- All outputs are registered.
- Reset values:
  - rx_rdy=0
  - all vld/sop/eop/mod=0
  - data=0
  - FSM=IDLE
  - FIFOs empty
  - rdy_ff=0
- rx_rdy is registered: it rises the first clock after reset release if space allows. rx_rdy = (data_used < DATA_DEPTH-4) && (tag_used < TAG_DEPTH-1). The margin absorbs the one-cycle-late vld.
- ip_rdy and arp_rdy are sampled into ip_rdy_ff and arp_rdy_ff. A beat at cycle n requires rdy_ff==1, i.e. rdy was high at n-1.
- Minimum latency from the input word carrying the EtherType (wcnt 3) to the first ip/arp beat is 3 cycles. Header words wait in the FIFO until the tag exists.
- Steady-state throughput: 2 output cycles per input word. Input is throttled by rx_rdy.
- Simultaneous tag push and pop is legal. So is simultaneous data push and pop.
- Reset mid-frame discards everything. No partial frame is emitted after reset.

## Structure
- Shared package constants:
  - ETH_TYPE_IP=16'h0800
  - ETH_TYPE_ARP=16'h0806
  - destination tag encoding: TAG_IP=0, TAG_ARP=1, TAG_DROP=2
- One sub-module, `sync_fifo`: parameterised width/depth, show-ahead, with a used-word count. It is instantiated twice: 35-bit data and 2-bit tag.

## Test plan
- **ARP frame:** send a 42-byte ARP request as 11 words, last mod=2 (ffffffff, ffff2c02, 03040507, 08060001, …, 010ac0a8), with ip_rdy=arp_rdy=1. Required: 21 arp beats ffff, ffff, ffff, 2c02 … 010a; sop on beat 0, eop on beat 20 with arp_mod=0; ip_vld never 1.
- **IP frame:** send a 48-byte frame of bytes 0x00..0x2f with EtherType patched to 0800, mod=0. Required: 24 ip beats 0001, 0203, … with bytes 12/13 = 08/00; eop on beat 23 with ip_mod=0.
- **Odd lengths:** send IP frames with mod=1 and mod=3. Required: mod=1 gives last beat = low half with ip_mod=1; mod=3 gives last beat = high half with ip_mod=1 and no extra beat.
- **Drop cases:** send EtherType 86dd, then a 2-word runt, then an ARP frame. Required: only the ARP frame appears; no vld on either port for the dropped frames.
- **Random backpressure:** drive $random on ip_rdy/arp_rdy and hold rx_vld as aggressively as rx_rdy allows, sending alternating IP/ARP frames ×20. Required: every vld has rdy high the previous cycle, including rx_vld vs rx_rdy; no data loss; frame order preserved.
- **Reset mid-frame:** assert rst_n=0 at word 5 of an IP frame. Required: all outputs 0 during reset; after release, a new ARP frame is output intact with no IP residue.
